// File: rtl/nios2_system_key_ctrl.sv
// Avalon-MM push-button controller: per-key 2-FF synchroniser and debounce FSM, sticky
// press capture (W1C), interrupt mask, and a polarity setting.
module nios2_system_key_ctrl #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_e;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_CONFIG  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q;
  logic             invert_q;
  logic             irq_q;
  logic [31:0]      readdata_q, readdata_d;
  state_e           state_q [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];

  logic             wr_en;
  logic             cfg_wr;
  logic             cfg_reload;
  logic [WIDTH-1:0] pressed_raw;
  logic [WIDTH-1:0] reload_raw;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] ecap_clr;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[31:WIDTH];

  assign wr_en       = chipselect & ~write_n;
  assign cfg_wr      = wr_en && (address == ADDR_CONFIG);
  assign cfg_reload  = cfg_wr && (writedata[0] != invert_q);
  assign pressed_raw = sync2_q ^ {WIDTH{invert_q}};
  assign reload_raw  = sync2_q ^ {WIDTH{writedata[0]}};
  assign ecap_clr    = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (state_q[i] == ST_COUNT) && (pressed_raw[i] != level_q[i]) &&
                  (cnt_q[i] == CNT_LAST);
    end
    // Only accepted presses capture; a polarity reload never does.
    edge_set  = accept & pressed_raw & ~{WIDTH{cfg_reload}};
    // Set is OR'ed after the clear, so a press beats a same-cycle W1C on that bit.
    edgecap_d = (edgecap_q & ~ecap_clr) | edge_set;

    readdata_d = '0;
    unique case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = level_q;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      ADDR_CONFIG:  readdata_d[0]         = invert_q;
    endcase
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      level_q    <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      invert_q   <= 1'b1;
      irq_q      <= 1'b0;
      readdata_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      edgecap_q  <= edgecap_d;
      irq_q      <= |(edgecap_q & irqmask_q);
      readdata_q <= readdata_d;
      if (wr_en && address == ADDR_IRQMASK) irqmask_q <= writedata[WIDTH-1:0];
      if (cfg_wr) invert_q <= writedata[0];

      for (int i = 0; i < WIDTH; i++) begin
        if (cfg_reload) begin
          state_q[i] <= ST_STABLE;
          cnt_q[i]   <= '0;
          level_q[i] <= reload_raw[i];
        end else begin
          unique case (state_q[i])
            ST_STABLE: begin
              if (pressed_raw[i] != level_q[i]) begin
                state_q[i] <= ST_COUNT;
                cnt_q[i]   <= '0;
              end
            end
            ST_COUNT: begin
              if (pressed_raw[i] == level_q[i]) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
              end else if (accept[i]) begin
                level_q[i] <= pressed_raw[i];
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
              end else begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios2_system_key_ctrl.sv
// Scenario bench for nios2_system_key_ctrl with a short debounce window (8 cycles).
// Read expectations go into a scoreboard queue; a monitor pops and compares them.
module tb_nios2_system_key_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  in_port;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] value;
  } rd_exp_t;

  rd_exp_t sb[$];
  rd_exp_t mon_item;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios2_system_key_ctrl #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  // Monitor: a read presented before this edge shows up on readdata just after it.
  always @(posedge clk) begin
    if (sb.size() != 0) begin
      mon_item = sb.pop_front();
      #1;
      n_vec++;
      if (readdata !== mon_item.value) begin
        n_err++;
        $display("FAIL %s: readdata=0x%08h expected 0x%08h", mon_item.name, readdata, mon_item.value);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (n) tick();
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] value, input string nm);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    sb.push_back('{name: nm, value: value});
    tick();
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    in_port    = 2'b11;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) tick();
    n_vec++;
    if (readdata !== 32'h0) begin n_err++; $display("FAIL reset readdata: got 0x%08h want 0x0", readdata); end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset irq: got %b want 0", irq); end
    reset = 1'b0;
    rd(2'd0, 32'h0, "reset DATA");
    rd(2'd1, 32'h0, "reset IRQMASK");
    rd(2'd2, 32'h0, "reset EDGECAP");
    rd(2'd3, 32'h1, "reset CONFIG");
  endtask

  task automatic test_press();
    in_port[0] = 1'b0;
    // Level flips on the 11th edge after the pin change; DATA shows it one edge later.
    for (int k = 1; k <= 12; k++) rd(2'd0, (k == 12) ? 32'h1 : 32'h0, "press DATA timing");
    idle(8);
    rd(2'd2, 32'h1, "press EDGECAP");
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL press irq masked: got %b want 0", irq); end
    wr(2'd1, 32'h1);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL press irq at mask write: got %b want 0", irq); end
    tick();
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL press irq after mask: got %b want 1", irq); end
    in_port[0] = 1'b1;
    idle(12);
    rd(2'd0, 32'h0, "release DATA");
    rd(2'd2, 32'h1, "release sets no capture");
    wr(2'd2, 32'h1);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL w1c irq same cycle: got %b want 1", irq); end
    tick();
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL w1c irq deassert: got %b want 0", irq); end
    rd(2'd2, 32'h0, "w1c EDGECAP");
  endtask

  task automatic test_bounce();
    for (int p = 0; p < 4; p++) begin
      in_port[1] = 1'b0;
      repeat (5) rd(2'd0, 32'h0, "bounce DATA low");
      in_port[1] = 1'b1;
      repeat (5) rd(2'd0, 32'h0, "bounce DATA high");
      n_vec++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL bounce irq: got %b want 0", irq); end
    end
    idle(10);
    rd(2'd0, 32'h0, "bounce DATA settled");
    rd(2'd2, 32'h0, "bounce EDGECAP");
  endtask

  task automatic test_w1c_race();
    in_port[0] = 1'b0;
    idle(12);
    rd(2'd2, 32'h1, "race key0 capture");
    wr(2'd1, 32'h3);
    in_port[1] = 1'b0;
    repeat (10) begin
      tick();
      n_vec++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL race irq pending: got %b want 1", irq); end
    end
    // Clearing both bits on the edge key1 is accepted: bit0 clears, bit1's set wins.
    wr(2'd2, 32'h3);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL race irq at clear: got %b want 1", irq); end
    rd(2'd2, 32'h2, "race EDGECAP");
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL race irq after: got %b want 1", irq); end
    rd(2'd0, 32'h3, "race DATA");
  endtask

  task automatic test_invert_reload();
    wr(2'd3, 32'h0);
    rd(2'd0, 32'h0, "reload DATA");
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL reload irq: got %b want 1", irq); end
    rd(2'd2, 32'h2, "reload EDGECAP");
    rd(2'd3, 32'h0, "reload CONFIG");
    idle(12);
    rd(2'd0, 32'h0, "reload DATA settled");
    rd(2'd2, 32'h2, "reload EDGECAP settled");
  endtask

  task automatic test_reg_width();
    wr(2'd1, 32'h1);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL mask irq at write: got %b want 1", irq); end
    tick();
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL mask irq deassert: got %b want 0", irq); end
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h3, "IRQMASK readback");
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL mask irq reassert: got %b want 1", irq); end
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'h0, "DATA ignores write");
    wr(2'd3, 32'hFFFF_FFFE);
    rd(2'd3, 32'h0, "CONFIG upper bits ignored");
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 32'h1, "CONFIG invert set");
    rd(2'd0, 32'h3, "reload to invert DATA");
    rd(2'd2, 32'h2, "reload to invert EDGECAP");
  endtask

  task automatic test_reset_mid();
    in_port = 2'b11;
    idle(12);
    rd(2'd0, 32'h0, "released DATA");
    in_port[0] = 1'b0;
    repeat (7) rd(2'd1, 32'h3, "pending IRQMASK");
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL pre-reset irq: got %b want 1", irq); end
    reset      = 1'b1;
    address    = 2'd1;
    chipselect = 1'b1;
    tick();
    reset      = 1'b0;
    chipselect = 1'b0;
    n_vec++;
    if (readdata !== 32'h0) begin n_err++; $display("FAIL mid reset readdata: got 0x%08h want 0x0", readdata); end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL mid reset irq: got %b want 0", irq); end
    repeat (5) rd(2'd2, 32'h0, "post-reset EDGECAP");
    repeat (6) rd(2'd0, 32'h0, "post-reset DATA");
    rd(2'd0, 32'h1, "post-reset accepted DATA");
    rd(2'd2, 32'h1, "post-reset EDGECAP set");
    rd(2'd1, 32'h0, "post-reset IRQMASK");
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL post-reset irq: got %b want 0", irq); end
  endtask

  task automatic test_back_to_back();
    in_port = 2'b11;
    idle(12);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 32'h0, "b2b cleared EDGECAP");
    wr(2'd1, 32'h2);
    in_port = 2'b00;
    idle(12);
    rd(2'd2, 32'h3, "b2b EDGECAP both");
    rd(2'd0, 32'h3, "b2b DATA both");
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL b2b irq: got %b want 1", irq); end
    wr(2'd2, 32'h2);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL b2b irq at clear: got %b want 1", irq); end
    tick();
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL b2b irq unmasked bit only: got %b want 0", irq); end
    rd(2'd2, 32'h1, "b2b EDGECAP after clear");
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_w1c_race();
    test_invert_reload();
    test_reg_width();
    test_reset_mid();
    test_back_to_back();
    idle(2);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d reads outstanding, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
